// File: rtl/matvec_pkg.sv
// Shared types and sizing helpers for the matrix-vector engine.
//   matvec_state_t : control FSM states
//   clog2_min1()   : $clog2 that never returns 0, for index/pointer widths
//   acc_width()    : result width that can hold COLS full-scale products
package matvec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } matvec_state_t;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int acc_width(input int dw, input int cols);
        return 2 * dw + $clog2(cols);
    endfunction

endpackage

// File: rtl/matvec_fifo.sv
// Synchronous show-ahead FIFO used for every A row buffer and the B buffer.
//   clk       : clock
//   i_clr     : synchronous flush (empties the FIFO)
//   i_wr_en   : push i_wr_data (ignored when full)
//   i_rd_en   : pop the head (ignored when empty)
//   o_rd_data : current head, valid one cycle after it was written
//   o_full    : FIFO holds DEPTH entries
module matvec_fifo
    import matvec_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_wr   = i_wr_en && !o_full && !i_clr;
    assign w_do_rd   = i_rd_en && (r_count != '0) && !i_clr;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_rd && !w_do_wr) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/matvec_mac_cell.sv
// One systolic MAC cell: acc += a*b while enabled, and forwards its enable
// and B operand one cycle later to the next cell in the chain.
//   clk    : clock
//   i_clr  : synchronous clear of accumulator and forwarding registers
//   i_en   : cell is consuming an operand pair this cycle
//   i_a    : A operand (head of this row's buffer)
//   i_b    : B operand (from previous cell or the B buffer)
//   o_en   : registered i_en for the next cell
//   o_b    : registered i_b for the next cell
//   o_acc  : accumulator
module matvec_mac_cell #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 19
) (
    input  logic                  clk,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_en,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [ACC_WIDTH-1:0]  o_acc
);

    logic                    r_en;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [ACC_WIDTH-1:0]    r_acc;
    logic [2*DATA_WIDTH-1:0] w_prod;

    assign w_prod = {{DATA_WIDTH{1'b0}}, i_a} * {{DATA_WIDTH{1'b0}}, i_b};
    assign o_en   = r_en;
    assign o_b    = r_b;
    assign o_acc  = r_acc;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_en  <= 1'b0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            r_en <= i_en;
            r_b  <= i_b;
            if (i_en) begin
                r_acc <= r_acc + ACC_WIDTH'(w_prod);
            end
        end
    end

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector multiply C = A*B over a skewed chain of ROWS MAC cells.
//   clk, rst            : clock, synchronous active-high reset
//   a_wr_en/row/data    : host write of one A element into a row buffer
//   b_wr_en/b_wr_data   : host write of one B element
//   start               : begin a computation (needs every buffer full)
//   clr                 : flush buffers and zero results (IDLE/DONE only)
//   busy                : COMPUTE or DRAIN in progress
//   done                : one-cycle pulse, c_data final
//   start_err           : one-cycle pulse for a start rejected on fill level
//   wr_ovf              : sticky, a write was dropped
//   c_data              : row i result at [i*ACC_WIDTH +: ACC_WIDTH]
//
// Host contract: writes and start/clr are single-cycle strobes with no
// back-pressure. A write lands only if the engine is not busy and its buffer
// is not full; otherwise it is dropped and wr_ovf latches. start is judged on
// the fill level before any same-cycle write, and clr beats start.
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, COLS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_wr_en,
    input  logic [clog2_min1(ROWS)-1:0]   a_wr_row,
    input  logic [DATA_WIDTH-1:0]         a_wr_data,
    input  logic                          b_wr_en,
    input  logic [DATA_WIDTH-1:0]         b_wr_data,
    input  logic                          start,
    input  logic                          clr,
    output logic                          busy,
    output logic                          done,
    output logic                          start_err,
    output logic                          wr_ovf,
    output logic [ROWS*ACC_WIDTH-1:0]     c_data
);

    localparam int ROW_W = clog2_min1(ROWS);
    localparam int CNT_W = clog2_min1((ROWS > COLS) ? ROWS : COLS);

    matvec_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_start_err;
    logic             r_wr_ovf;

    logic [ROWS-1:0]       w_a_full;
    logic [ROWS-1:0]       w_a_push;
    logic                  w_a_row_full;
    logic                  w_b_full;
    logic                  w_b_push;
    logic [DATA_WIDTH-1:0] w_b_head;
    logic                  w_all_full;
    logic                  w_idle_like;
    logic                  w_clr_ok;
    logic                  w_start_ok;
    logic                  w_flush;
    logic                  w_acc_clr;
    logic                  w_a_ovf;
    logic                  w_b_ovf;

    // Chain taps: index i feeds cell i, index i+1 is cell i's forwarded copy.
    logic                  w_en   [ROWS+1];
    logic [DATA_WIDTH-1:0] w_b    [ROWS+1];
    logic [DATA_WIDTH-1:0] w_a_head [ROWS];
    logic [ACC_WIDTH-1:0]  w_acc  [ROWS];

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_all_full  = (&w_a_full) && w_b_full;
    assign w_clr_ok    = clr && w_idle_like;
    assign w_start_ok  = start && !clr && w_idle_like && w_all_full;
    assign w_flush     = rst || w_clr_ok;
    assign w_acc_clr   = rst || w_clr_ok || w_start_ok;

    always_comb begin
        w_a_row_full = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (a_wr_row == ROW_W'(r)) begin
                w_a_row_full = w_a_full[r];
            end
        end
    end

    assign w_a_ovf  = a_wr_en && (r_busy || w_a_row_full);
    assign w_b_ovf  = b_wr_en && (r_busy || w_b_full);
    assign w_b_push = b_wr_en && !r_busy && !w_b_full;

    // Cell 0 is fed straight from the FSM and the B head; B pops with it.
    assign w_en[0] = (r_state == ST_COMPUTE);
    assign w_b[0]  = w_b_head;

    matvec_fifo #(.DEPTH(COLS), .WIDTH(DATA_WIDTH)) u_b_fifo (
        .clk       (clk),
        .i_clr     (w_flush),
        .i_wr_en   (w_b_push),
        .i_wr_data (b_wr_data),
        .i_rd_en   (w_en[0]),
        .o_rd_data (w_b_head),
        .o_full    (w_b_full)
    );

    for (genvar g = 0; g < ROWS; g++) begin : g_row
        assign w_a_push[g] = a_wr_en && !r_busy && (a_wr_row == ROW_W'(g)) && !w_a_full[g];

        // The row buffer pops exactly when its cell consumes an operand pair.
        matvec_fifo #(.DEPTH(COLS), .WIDTH(DATA_WIDTH)) u_a_fifo (
            .clk       (clk),
            .i_clr     (w_flush),
            .i_wr_en   (w_a_push[g]),
            .i_wr_data (a_wr_data),
            .i_rd_en   (w_en[g]),
            .o_rd_data (w_a_head[g]),
            .o_full    (w_a_full[g])
        );

        matvec_mac_cell #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_cell (
            .clk   (clk),
            .i_clr (w_acc_clr),
            .i_en  (w_en[g]),
            .i_a   (w_a_head[g]),
            .i_b   (w_b[g]),
            .o_en  (w_en[g+1]),
            .o_b   (w_b[g+1]),
            .o_acc (w_acc[g])
        );

        assign c_data[g*ACC_WIDTH +: ACC_WIDTH] = w_acc[g];
    end

    // COMPUTE runs COLS cycles feeding cell 0; DRAIN runs ROWS cycles so the
    // last cell, ROWS-1 cycles behind, finishes before done is raised.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            r_wr_ovf    <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            if (w_a_ovf || w_b_ovf) begin
                r_wr_ovf <= 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (clr) begin
                        r_state <= ST_IDLE;
                    end else if (start) begin
                        if (w_all_full) begin
                            r_state <= ST_COMPUTE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_start_err <= 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (r_cnt == CNT_W'(COLS - 1)) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == CNT_W'(ROWS - 1)) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign start_err = r_start_err;
    assign wr_ovf    = r_wr_ovf;

endmodule

// File: tb/tb_matvec_engine.sv
// Bench for matvec_engine: directed loads with hand-computed results, and a
// queue-based model of the buffers and job timing checked every cycle.
module tb_matvec_engine;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int ACC  = 19;
    localparam int RW   = 3;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b1;
    logic                 a_wr_en   = 1'b0;
    logic [RW-1:0]        a_wr_row  = '0;
    logic [DW-1:0]        a_wr_data = '0;
    logic                 b_wr_en   = 1'b0;
    logic [DW-1:0]        b_wr_data = '0;
    logic                 start     = 1'b0;
    logic                 clr       = 1'b0;
    logic                 busy;
    logic                 done;
    logic                 start_err;
    logic                 wr_ovf;
    logic [ROWS*ACC-1:0]  c_data;

    matvec_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_wr_en   (a_wr_en),
        .a_wr_row  (a_wr_row),
        .a_wr_data (a_wr_data),
        .b_wr_en   (b_wr_en),
        .b_wr_data (b_wr_data),
        .start     (start),
        .clr       (clr),
        .busy      (busy),
        .done      (done),
        .start_err (start_err),
        .wr_ovf    (wr_ovf),
        .c_data    (c_data)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_bus(input string name, input logic [ROWS*ACC-1:0] act,
                           input logic [ROWS*ACC-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint row_c(input int i);
        return longint'(c_data[i*ACC +: ACC]);
    endfunction

    // ---------------- behavioural model ----------------
    // Buffers are plain queues; a job snapshots the dot products at accept
    // time and publishes them COLS+ROWS cycles later.
    logic [DW-1:0]       m_aq [ROWS][$];
    logic [DW-1:0]       m_bq [$];
    int                  m_busy_cnt = 0;
    logic                m_done  = 1'b0;
    logic                m_err   = 1'b0;
    logic                m_ovf   = 1'b0;
    logic                m_valid = 1'b0;
    logic [ROWS*ACC-1:0] m_c     = '0;
    logic [ROWS*ACC-1:0] m_pend  = '0;
    longint              m_sum;
    logic                m_full_all;

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (rst) begin
            for (int i = 0; i < ROWS; i++) m_aq[i].delete();
            m_bq.delete();
            m_busy_cnt = 0;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_ovf  = 1'b0;
            m_c    = '0;
            m_pend = '0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_busy_cnt > 0) begin
                if (a_wr_en || b_wr_en) m_ovf = 1'b1;
                m_busy_cnt--;
                if (m_busy_cnt == 0) begin
                    m_done = 1'b1;
                    m_c    = m_pend;
                end
            end else begin
                m_full_all = (m_bq.size() == COLS);
                for (int i = 0; i < ROWS; i++)
                    if (m_aq[i].size() != COLS) m_full_all = 1'b0;
                if (a_wr_en) begin
                    if (m_aq[a_wr_row].size() == COLS) m_ovf = 1'b1;
                    else if (!clr) m_aq[a_wr_row].push_back(a_wr_data);
                end
                if (b_wr_en) begin
                    if (m_bq.size() == COLS) m_ovf = 1'b1;
                    else if (!clr) m_bq.push_back(b_wr_data);
                end
                if (clr) begin
                    for (int i = 0; i < ROWS; i++) m_aq[i].delete();
                    m_bq.delete();
                    m_c = '0;
                end else if (start) begin
                    if (m_full_all) begin
                        for (int i = 0; i < ROWS; i++) begin
                            m_sum = 0;
                            for (int j = 0; j < COLS; j++)
                                m_sum += longint'(m_aq[i][j]) * longint'(m_bq[j]);
                            m_pend[i*ACC +: ACC] = ACC'(m_sum);
                            m_aq[i].delete();
                        end
                        m_bq.delete();
                        m_c = '0;
                        m_busy_cnt = COLS + ROWS;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", longint'(busy), longint'(m_busy_cnt > 0));
            chk("done", longint'(done), longint'(m_done));
            chk("start_err", longint'(start_err), longint'(m_err));
            chk("wr_ovf", longint'(wr_ovf), longint'(m_ovf));
            if (m_busy_cnt == 0) chk_bus("c_data", c_data, m_c);
        end
    end

    // ---------------- driver tasks ----------------
    int ta  [ROWS][COLS];
    int tbv [COLS];

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic write_a(input int row, input int d);
        a_wr_en   = 1'b1;
        a_wr_row  = RW'(row);
        a_wr_data = DW'(d);
        cyc();
        a_wr_en   = 1'b0;
    endtask

    task automatic write_b(input int d);
        b_wr_en   = 1'b1;
        b_wr_data = DW'(d);
        cyc();
        b_wr_en   = 1'b0;
    endtask

    task automatic load_ab(input int nb);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                write_a(i, ta[i][j]);
        for (int j = 0; j < nb; j++) write_b(tbv[j]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // lat = index of the cycle after the accept edge in which done is seen
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int k = 1; k <= 100; k++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
            cyc();
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int lat;
    int bcnt;

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("reset_busy", longint'(busy), 0);
        chk("reset_wr_ovf", longint'(wr_ovf), 0);
        chk_bus("reset_c_data", c_data, '0);

        // basic sum: A[i][j]=j+1, B=1 -> every C = 36
        for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) ta[i][j] = j + 1;
        for (int j = 0; j < COLS; j++) tbv[j] = 1;
        load_ab(COLS);
        pulse_start();
        wait_done(lat, bcnt);
        chk("basic_latency", lat, 17);
        for (int i = 0; i < ROWS; i++) chk("basic_c", row_c(i), 36);

        // row scaling, loaded from DONE: C[i] = 36*(i+1)
        for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) ta[i][j] = i + 1;
        for (int j = 0; j < COLS; j++) tbv[j] = j + 1;
        load_ab(COLS);
        pulse_start();
        wait_done(lat, bcnt);
        chk("scale_latency", lat, 17);
        chk("scale_busy_cycles", bcnt, 16);
        chk("scale_c0", row_c(0), 36);
        chk("scale_c7", row_c(7), 288);

        // full-scale operands: 8*255*255 = 520200
        for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) ta[i][j] = 255;
        for (int j = 0; j < COLS; j++) tbv[j] = 255;
        load_ab(COLS);
        pulse_start();
        wait_done(lat, bcnt);
        chk("max_latency", lat, 17);
        for (int i = 0; i < ROWS; i++) chk("max_c", row_c(i), 520200);

        // incomplete B load: rejected start, then completion
        for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) ta[i][j] = j + 1;
        for (int j = 0; j < COLS; j++) tbv[j] = 1;
        load_ab(COLS - 1);
        pulse_start();
        chk("incomplete_start_err", longint'(start_err), 1);
        chk("incomplete_busy", longint'(busy), 0);
        cyc();
        chk("incomplete_err_pulse", longint'(start_err), 0);
        write_b(1);
        pulse_start();
        wait_done(lat, bcnt);
        chk("incomplete_latency", lat, 17);
        chk("incomplete_c0", row_c(0), 36);

        // write during COMPUTE: dropped, flagged, result intact
        load_ab(COLS);
        pulse_start();
        cyc();
        cyc();
        write_a(2, 99);
        wait_done(lat, bcnt);
        chk("abuse_done_seen", longint'(lat != 0), 1);
        chk("abuse_wr_ovf", longint'(wr_ovf), 1);
        chk("abuse_c2", row_c(2), 36);

        // reset in the middle of COMPUTE
        load_ab(COLS);
        pulse_start();
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_wr_ovf", longint'(wr_ovf), 0);
        chk_bus("midrst_c_data", c_data, '0);
        pulse_start();
        chk("midrst_empty_start_err", longint'(start_err), 1);

        // write to a full buffer in IDLE, then clr+start together
        load_ab(COLS);
        write_b(5);
        chk("idle_full_wr_ovf", longint'(wr_ovf), 1);
        clr   = 1'b1;
        start = 1'b1;
        cyc();
        clr   = 1'b0;
        start = 1'b0;
        chk("clr_start_busy", longint'(busy), 0);
        chk("clr_start_err", longint'(start_err), 0);
        pulse_start();
        chk("after_clr_start_err", longint'(start_err), 1);
        chk("after_clr_busy", longint'(busy), 0);

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
